// File: rtl/aes_req_arbiter_if.sv
// Requester, response and engine-side signal bundle for aes_req_arbiter.
// slave = arbiter view, master = requester fabric / engine view.
interface aes_req_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ*128-1:0] req_key;
  logic                resp_valid;
  logic                resp_ready;
  logic [127:0]        resp_data;
  logic [IDW-1:0]      resp_id;
  logic                resp_err;
  logic                busy;
  logic                eng_start;
  logic [127:0]        eng_in;
  logic [127:0]        eng_key;
  logic [127:0]        eng_out;
  logic                eng_done;

  modport slave (
    input  req_valid, req_data, req_key, resp_ready, eng_out, eng_done,
    output req_ready, resp_valid, resp_data, resp_id, resp_err, busy,
           eng_start, eng_in, eng_key
  );

  modport master (
    output req_valid, req_data, req_key, resp_ready, eng_out, eng_done,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err, busy,
           eng_start, eng_in, eng_key
  );
endinterface

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one iterative AES-128 engine between NREQ requesters,
// with registered engine operands, response handshake and a run watchdog.
module aes_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned NR      = 10,
  parameter int unsigned TIMEOUT = NR + 4,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_req_arbiter_if.slave  bus
);
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [127:0]   in_q, in_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   data_q, data_d;
  logic           err_q, err_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic           hi_vld, lo_vld, grant_vld;
  logic [IDW-1:0] hi_idx, lo_idx, grant_idx;
  logic [127:0]   sel_data, sel_key;

  // Round-robin search: first pass above last, second pass wraps to 0..last.
  always_comb begin
    hi_vld   = 1'b0;
    hi_idx   = '0;
    lo_vld   = 1'b0;
    lo_idx   = '0;
    sel_data = '0;
    sel_key  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!hi_vld && (i > 32'(last_q)) && bus.req_valid[i]) begin
        hi_vld = 1'b1;
        hi_idx = IDW'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!lo_vld && (i <= 32'(last_q)) && bus.req_valid[i]) begin
        lo_vld = 1'b1;
        lo_idx = IDW'(i);
      end
    end
    grant_vld = hi_vld || lo_vld;
    grant_idx = hi_vld ? hi_idx : lo_idx;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        sel_data = bus.req_data[i*128 +: 128];
        sel_key  = bus.req_key[i*128 +: 128];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    id_d          = id_q;
    in_d          = in_q;
    key_d         = key_q;
    data_d        = data_q;
    err_d         = err_q;
    wd_d          = wd_q;
    bus.req_ready = '0;
    bus.eng_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = (IDW'(i) == grant_idx);
          end
          in_d    = sel_data;
          key_d   = sel_key;
          id_d    = grant_idx;
          last_d  = grant_idx;
          wd_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Dropping start with done keeps the engine from relaunching.
        bus.eng_start = !bus.eng_done;
        wd_d          = wd_q + 1'b1;
        if (bus.eng_done) begin
          data_d  = bus.eng_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      in_q    <= '0;
      key_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      in_q    <= in_d;
      key_q   <= key_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.resp_valid = (state_q == RESP);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_err   = err_q;
  assign bus.eng_in     = in_q;
  assign bus.eng_key    = key_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a cycle-accurate stub engine
// (loads on first start cycle, pulses done NR+1 cycles later, optional hang).
module tb_aes_req_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned NR   = 10;
  localparam int unsigned IDW  = 2;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK     = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;
  int   done_cnt;
  logic stub_hang;
  logic [4:0] ecnt;
  logic [127:0] pt_v  [NREQ];
  logic [127:0] key_v [NREQ];

  aes_req_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  aes_req_arbiter #(.NREQ(NREQ), .NR(NR), .TIMEOUT(NR + 4), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub engine: FIPS vector maps to its real ciphertext, anything else to a simple mix.
  function automatic logic [127:0] ct_of(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ecnt <= '0;
    else if (!bus.eng_start) ecnt <= '0;
    else                    ecnt <= ecnt + 5'd1;
  end

  assign bus.eng_done = !stub_hang && (ecnt == 5'(NR + 1));
  assign bus.eng_out  = bus.eng_done ? ct_of(bus.eng_in, bus.eng_key) : JUNK;

  always @(posedge clk) if (bus.eng_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  int d0;

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    done_cnt  = 0;
    stub_hang = 1'b0;
    rst_n     = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    pt_v[0]  = FIPS_PT;
    key_v[0] = FIPS_KEY;
    for (int i = 1; i < NREQ; i++) begin
      pt_v[i]  = {16{8'(8'h10 + i)}};
      key_v[i] = {8{16'(16'h2000 + 16'h0101 * i)}};
    end
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[128*i +: 128] = pt_v[i];
      bus.req_key[128*i +: 128]  = key_v[i];
    end

    // Reset values
    step(1);
    chk("rst_req_ready",  128'(bus.req_ready), 128'h0);
    chk("rst_resp_valid", 128'(bus.resp_valid), 128'h0);
    chk("rst_resp_data",  bus.resp_data, 128'h0);
    chk("rst_resp_id",    128'(bus.resp_id), 128'h0);
    chk("rst_resp_err",   128'(bus.resp_err), 128'h0);
    chk("rst_busy",       128'(bus.busy), 128'h0);
    chk("rst_eng_start",  128'(bus.eng_start), 128'h0);
    chk("rst_eng_in",     bus.eng_in, 128'h0);
    chk("rst_eng_key",    bus.eng_key, 128'h0);
    rst_n = 1'b1;
    step(1);

    // Single run, FIPS-197 C.1
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", 128'(bus.req_ready), 128'h1);
    d0 = done_cnt;
    step(1);
    bus.req_valid = '0;
    chk("single_busy",   128'(bus.busy), 128'h1);
    chk("single_start",  128'(bus.eng_start), 128'h1);
    chk("single_eng_in", bus.eng_in, FIPS_PT);
    chk("single_eng_key", bus.eng_key, FIPS_KEY);
    step(11);
    chk("single_done_a12",  128'(bus.eng_done), 128'h1);
    chk("single_start_a12", 128'(bus.eng_start), 128'h0);
    chk("single_rv_a12",    128'(bus.resp_valid), 128'h0);
    chk("single_in_stable", bus.eng_in, FIPS_PT);
    step(1);
    chk("single_rv_a13", 128'(bus.resp_valid), 128'h1);
    chk("single_data",   bus.resp_data, FIPS_CT);
    chk("single_id",     128'(bus.resp_id), 128'h0);
    chk("single_err",    128'(bus.resp_err), 128'h0);
    chk("single_ndone",  128'(done_cnt - d0), 128'h1);
    bus.resp_ready = 1'b1;
    step(1);
    chk("single_rv_drop", 128'(bus.resp_valid), 128'h0);
    chk("single_idle",    128'(bus.busy), 128'h0);

    // Round robin, all valid, grants 14 cycles apart
    do_reset();
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_ready%0d", i), 128'(bus.req_ready), 128'(4'b0001 << (i % 4)));
      step(13);
      chk($sformatf("rr_rv%0d", i),   128'(bus.resp_valid), 128'h1);
      chk($sformatf("rr_id%0d", i),   128'(bus.resp_id), 128'(i % 4));
      chk($sformatf("rr_data%0d", i), bus.resp_data, ct_of(pt_v[i % 4], key_v[i % 4]));
      chk($sformatf("rr_rdy_resp%0d", i), 128'(bus.req_ready), 128'h0);
      if (i < 4) step(1);
    end

    // Back-pressure: hold the response for 20 cycles
    bus.resp_ready = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("bp_rv",    128'(bus.resp_valid), 128'h1);
      chk("bp_data",  bus.resp_data, FIPS_CT);
      chk("bp_id",    128'(bus.resp_id), 128'h0);
      chk("bp_start", 128'(bus.eng_start), 128'h0);
      chk("bp_ready", 128'(bus.req_ready), 128'h0);
    end
    chk("bp_no_redone", 128'(done_cnt - d0), 128'h0);
    bus.resp_ready = 1'b1;
    step(1);
    chk("bp_next_grant", 128'(bus.req_ready), 128'h2);
    step(1);
    bus.req_valid = '0;
    step(12);
    chk("bp_run_rv", 128'(bus.resp_valid), 128'h1);
    chk("bp_run_id", 128'(bus.resp_id), 128'h1);
    step(1);

    // Request withdrawn before the handshake edge
    bus.req_valid = 4'b0100;
    #1;
    chk("drop_ready", 128'(bus.req_ready), 128'h4);
    bus.req_valid = '0;
    step(1);
    chk("drop_busy", 128'(bus.busy), 128'h0);

    // Watchdog: engine never completes
    stub_hang     = 1'b1;
    bus.req_valid = 4'b0100;
    #1;
    chk("wd_ready", 128'(bus.req_ready), 128'h4);
    step(1);
    bus.req_valid = '0;
    step(13);
    chk("wd_rv_a14",    128'(bus.resp_valid), 128'h0);
    chk("wd_start_a14", 128'(bus.eng_start), 128'h1);
    step(1);
    chk("wd_rv_a15", 128'(bus.resp_valid), 128'h1);
    chk("wd_err",    128'(bus.resp_err), 128'h1);
    chk("wd_data",   bus.resp_data, 128'h0);
    chk("wd_id",     128'(bus.resp_id), 128'h2);
    stub_hang = 1'b0;
    step(1);
    bus.req_valid = 4'b1000;
    #1;
    chk("wd_next_ready", 128'(bus.req_ready), 128'h8);
    step(1);
    bus.req_valid = '0;
    step(12);
    chk("wd_next_rv",   128'(bus.resp_valid), 128'h1);
    chk("wd_next_err",  128'(bus.resp_err), 128'h0);
    chk("wd_next_id",   128'(bus.resp_id), 128'h3);
    chk("wd_next_data", bus.resp_data, ct_of(pt_v[3], key_v[3]));
    step(1);

    // Reset in the middle of a run
    bus.req_valid = 4'b0001;
    step(1);
    bus.req_valid = '0;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy",   128'(bus.busy), 128'h0);
    chk("mrst_start",  128'(bus.eng_start), 128'h0);
    chk("mrst_eng_in", bus.eng_in, 128'h0);
    chk("mrst_eng_key", bus.eng_key, 128'h0);
    chk("mrst_rv",     128'(bus.resp_valid), 128'h0);
    #2;
    rst_n = 1'b1;
    step(1);
    chk("mrst_idle_rv", 128'(bus.resp_valid), 128'h0);
    bus.req_valid = 4'b0010;
    #1;
    chk("mrst_ready", 128'(bus.req_ready), 128'h2);
    step(1);
    bus.req_valid = '0;
    step(11);
    chk("mrst_rv_a12", 128'(bus.resp_valid), 128'h0);
    step(1);
    chk("mrst_rv_a13", 128'(bus.resp_valid), 128'h1);
    chk("mrst_id",     128'(bus.resp_id), 128'h1);
    chk("mrst_data",   bus.resp_data, ct_of(pt_v[1], key_v[1]));
    step(2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
